// File: rtl/nbody_pkg.sv
// Shared types and constants for the N-body step sequencer: FSM state encoding,
// bus opcodes and STATUS word bit positions.
package nbody_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ACCEL     = 3'd1,
        ACC_DRAIN = 3'd2,
        POS       = 3'd3,
        POS_DRAIN = 3'd4,
        DONE      = 3'd5
    } state_t;

    localparam int OP_CTRL      = 0;
    localparam int OP_NBODIES   = 1;
    localparam int OP_STEPS     = 2;
    localparam int OP_CHAN_BASE = 3;

    localparam int ST_DONE  = 0;
    localparam int ST_BUSY  = 1;
    localparam int ST_STATE = 2;
    localparam int ST_ERR   = 5;
    localparam int ST_STEP  = 30;

endpackage

// File: rtl/nbody_lat_pipe.sv
// Fixed-latency valid+payload shift register; a synchronous clear drops every
// in-flight entry so nothing emerges after an abort.
module nbody_lat_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             busy_o
);

    logic [DEPTH-1:0] vld_q;
    logic [WIDTH-1:0] dat_q [DEPTH];

    // Payload is zeroed on invalid entries so data_o reads 0 whenever valid_o is low.
    always_ff @(posedge clk) begin
        if (!rst || clear_i) begin
            vld_q <= '0;
            for (int s = 0; s < DEPTH; s++) dat_q[s] <= '0;
        end else begin
            vld_q[0] <= valid_i;
            dat_q[0] <= valid_i ? data_i : '0;
            for (int s = 1; s < DEPTH; s++) begin
                vld_q[s] <= vld_q[s-1];
                dat_q[s] <= dat_q[s-1];
            end
        end
    end

    assign valid_o = vld_q[DEPTH-1];
    assign data_o  = dat_q[DEPTH-1];
    assign busy_o  = |vld_q;

endmodule

// File: rtl/nbody_seq.sv
// N-body step sequencer: bus register file, go/done handshake, i/j pair issue
// and latency-matched velocity/position write-back strobes.
module nbody_seq
    import nbody_pkg::*;
#(
    parameter int BODIES     = 512,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 16,
    parameter int DIMS       = 2,
    parameter int ACC_LAT    = 60,
    parameter int UPD_LAT    = 20,
    parameter int BA         = $clog2(BODIES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  chipselect,
    input  logic                  write,
    input  logic                  read,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] writedata,
    output logic [DATA_WIDTH-1:0] readdata,
    output logic [BA-1:0]         sw_waddr,
    output logic [DATA_WIDTH-1:0] sw_wdata,
    output logic [2*DIMS:0]       sw_wren,
    output logic                  pair_valid,
    output logic [BA-1:0]         pair_i,
    output logic [BA-1:0]         pair_j,
    output logic                  pair_last,
    output logic                  vel_wren,
    output logic [BA-1:0]         vel_addr,
    output logic                  pos_rd_valid,
    output logic [BA-1:0]         pos_rd_addr,
    output logic                  pos_wren,
    output logic [BA-1:0]         pos_waddr,
    output logic                  busy,
    output logic                  done
);

    localparam int OPW = ADDR_WIDTH - BA;
    localparam int NCH = 2 * DIMS + 1;
    localparam logic [OPW-1:0] OpCtrl    = OPW'(OP_CTRL);
    localparam logic [OPW-1:0] OpNBodies = OPW'(OP_NBODIES);
    localparam logic [OPW-1:0] OpSteps   = OPW'(OP_STEPS);
    localparam logic [OPW-1:0] OpChanLo  = OPW'(OP_CHAN_BASE);
    localparam logic [OPW-1:0] OpChanHi  = OPW'(OP_CHAN_BASE + NCH);

    state_t                  state_q;
    logic [BA:0]             nBodies_q;
    logic [31:0]             steps_q, stepCnt_q;
    logic [BA-1:0]           i_q, j_q, k_q;
    logic                    err_q, done_q;
    logic [DATA_WIDTH-1:0]   readData_q, status;
    logic                    pairValid_q, pairLast_q, posRdValid_q;
    logic [BA-1:0]           pairI_q, pairJ_q, posRdAddr_q;

    logic [OPW-1:0] opcode, chanSel;
    logic           busWr, wrCtrl, abortNow, isBusy, isChan, chanOk, badWr;
    logic           lastJ, lastI, lastK, accBusy, posBusy;
    logic [BA:0]    nMinus1;
    logic [31:0]    stepsEff;

    assign opcode   = addr[ADDR_WIDTH-1:BA];
    assign chanSel  = opcode - OpChanLo;
    assign busWr    = chipselect && write;
    assign wrCtrl   = busWr && (opcode == OpCtrl);
    assign abortNow = wrCtrl && writedata[1];
    assign isBusy   = (state_q != IDLE) && (state_q != DONE);
    assign isChan   = busWr && (opcode >= OpChanLo) && (opcode < OpChanHi);
    assign chanOk   = isChan && !isBusy && rst;
    assign badWr    = busWr && isBusy &&
                      (isChan || opcode == OpNBodies || opcode == OpSteps);

    assign nMinus1  = nBodies_q - 1'b1;
    assign lastJ    = ({1'b0, j_q} == nMinus1);
    assign lastI    = ({1'b0, i_q} == nMinus1);
    assign lastK    = ({1'b0, k_q} == nMinus1);
    assign stepsEff = (steps_q == 32'd0) ? 32'd1 : steps_q;

    // Software RAM writes are a same-cycle pass-through, suppressed while a run owns the RAMs.
    assign sw_wren  = chanOk ? (NCH'(1'b1) << chanSel) : '0;
    assign sw_waddr = chanOk ? addr[BA-1:0] : '0;
    assign sw_wdata = chanOk ? writedata : '0;

    always_comb begin
        status                  = '0;
        status[ST_DONE]         = done_q;
        status[ST_BUSY]         = isBusy;
        status[ST_STATE +: 3]   = state_q;
        status[ST_ERR]          = err_q;
        status[ST_STEP +: 32]   = stepCnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            nBodies_q    <= '0;
            steps_q      <= '0;
            stepCnt_q    <= '0;
            i_q          <= '0;
            j_q          <= '0;
            k_q          <= '0;
            err_q        <= 1'b0;
            done_q       <= 1'b0;
            readData_q   <= '0;
            pairValid_q  <= 1'b0;
            pairLast_q   <= 1'b0;
            pairI_q      <= '0;
            pairJ_q      <= '0;
            posRdValid_q <= 1'b0;
            posRdAddr_q  <= '0;
        end else begin
            pairValid_q  <= 1'b0;
            pairLast_q   <= 1'b0;
            pairI_q      <= '0;
            pairJ_q      <= '0;
            posRdValid_q <= 1'b0;
            posRdAddr_q  <= '0;

            if (chipselect && read) readData_q <= status;
            if (badWr) err_q <= 1'b1;
            if (wrCtrl && !writedata[0]) err_q <= 1'b0;
            if (busWr && opcode == OpNBodies && !isBusy) nBodies_q <= writedata[BA:0];
            if (busWr && opcode == OpSteps && !isBusy) steps_q <= writedata[31:0];

            if (abortNow) begin
                state_q <= IDLE;
                done_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: if (wrCtrl && writedata[0]) begin
                        if (nBodies_q >= (BA+1)'(2)) begin
                            state_q   <= ACCEL;
                            i_q       <= '0;
                            j_q       <= '0;
                            stepCnt_q <= '0;
                        end else begin
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                    // The diagonal slot is still walked so pair_last marks the final i.
                    ACCEL: begin
                        pairValid_q <= (i_q != j_q);
                        pairI_q     <= i_q;
                        pairJ_q     <= j_q;
                        pairLast_q  <= lastJ;
                        if (lastJ) begin
                            j_q <= '0;
                            if (lastI) begin
                                i_q     <= '0;
                                state_q <= ACC_DRAIN;
                            end else begin
                                i_q <= i_q + 1'b1;
                            end
                        end else begin
                            j_q <= j_q + 1'b1;
                        end
                    end
                    ACC_DRAIN: if (!pairLast_q && !accBusy) begin
                        state_q <= POS;
                        k_q     <= '0;
                    end
                    POS: begin
                        posRdValid_q <= 1'b1;
                        posRdAddr_q  <= k_q;
                        if (lastK) state_q <= POS_DRAIN;
                        else       k_q     <= k_q + 1'b1;
                    end
                    POS_DRAIN: if (!posRdValid_q && !posBusy) begin
                        stepCnt_q <= stepCnt_q + 32'd1;
                        if (stepCnt_q + 32'd1 == stepsEff) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            state_q <= ACCEL;
                            i_q     <= '0;
                            j_q     <= '0;
                        end
                    end
                    DONE: if (wrCtrl && !writedata[0]) begin
                        done_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    nbody_lat_pipe #(.WIDTH(BA), .DEPTH(ACC_LAT)) accPipe (
        .clk     (clk),
        .rst     (rst),
        .clear_i (abortNow),
        .valid_i (pairLast_q),
        .data_i  (pairI_q),
        .valid_o (vel_wren),
        .data_o  (vel_addr),
        .busy_o  (accBusy)
    );

    nbody_lat_pipe #(.WIDTH(BA), .DEPTH(UPD_LAT)) posPipe (
        .clk     (clk),
        .rst     (rst),
        .clear_i (abortNow),
        .valid_i (posRdValid_q),
        .data_i  (posRdAddr_q),
        .valid_o (pos_wren),
        .data_o  (pos_waddr),
        .busy_o  (posBusy)
    );

    assign readdata     = readData_q;
    assign pair_valid   = pairValid_q;
    assign pair_i       = pairI_q;
    assign pair_j       = pairJ_q;
    assign pair_last    = pairLast_q;
    assign pos_rd_valid = posRdValid_q;
    assign pos_rd_addr  = posRdAddr_q;
    assign busy         = isBusy;
    assign done         = done_q;

endmodule

// File: tb/tb_nbody_seq.sv
// Self-checking bench for nbody_seq: bus-write vector table plus scoreboarded
// pair issue, velocity and position write-back streams.
module tb_nbody_seq;

    localparam int ACC_LAT = 4;
    localparam int UPD_LAT = 2;

    logic        clk, rst, chipselect, write, read;
    logic [15:0] addr;
    logic [63:0] writedata, readdata, sw_wdata;
    logic [8:0]  sw_waddr, pair_i, pair_j, vel_addr, pos_rd_addr, pos_waddr;
    logic [4:0]  sw_wren;
    logic        pair_valid, pair_last, vel_wren, pos_rd_valid, pos_wren, busy, done;

    nbody_seq #(.BODIES(512), .DATA_WIDTH(64), .ADDR_WIDTH(16), .DIMS(2),
                .ACC_LAT(ACC_LAT), .UPD_LAT(UPD_LAT)) dut (
        .clk(clk), .rst(rst), .chipselect(chipselect), .write(write), .read(read),
        .addr(addr), .writedata(writedata), .readdata(readdata),
        .sw_waddr(sw_waddr), .sw_wdata(sw_wdata), .sw_wren(sw_wren),
        .pair_valid(pair_valid), .pair_i(pair_i), .pair_j(pair_j), .pair_last(pair_last),
        .vel_wren(vel_wren), .vel_addr(vel_addr),
        .pos_rd_valid(pos_rd_valid), .pos_rd_addr(pos_rd_addr),
        .pos_wren(pos_wren), .pos_waddr(pos_waddr), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [8:0] i;
        logic [8:0] j;
        logic       last;
    } pair_t;

    typedef struct {
        logic [6:0]  op;
        logic [8:0]  idx;
        logic [63:0] data;
        logic [4:0]  expWren;
    } vec_t;

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    bit     monOn = 1'b0;
    int     curN = 0;
    int     pairCnt, velCnt, posCnt;
    pair_t  pairQ[$];
    pair_t  monPair;
    logic [8:0] velQ[$];
    logic [8:0] posQ[$];
    longint lastCycQ[$];
    longint posCycQ[$];
    logic [63:0] st;
    vec_t   vecs[7];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Scoreboard: pops model expectations as the DUT produces pairs and write-backs.
    always @(negedge clk) begin
        if (monOn) begin
            if (pair_valid) begin
                pairCnt++;
                if (pairQ.size() == 0) checkOutput("pair_unexpected", 1, 0);
                else begin
                    monPair = pairQ.pop_front();
                    checkOutput("pair", {pair_i, pair_j, pair_last}, monPair);
                end
            end else if (pair_last) begin
                checkOutput("pair_last_diag", {pair_i, pair_j}, {9'(curN - 1), 9'(curN - 1)});
            end
            if (pair_last) lastCycQ.push_back(cyc);
            if (vel_wren) begin
                velCnt++;
                if (lastCycQ.size() == 0 || velQ.size() == 0) checkOutput("vel_unexpected", 1, 0);
                else begin
                    checkOutput("vel_lat", cyc, lastCycQ.pop_front() + ACC_LAT);
                    checkOutput("vel_addr", vel_addr, velQ.pop_front());
                end
            end
            if (pos_rd_valid) posCycQ.push_back(cyc);
            if (pos_wren) begin
                posCnt++;
                if (posCycQ.size() == 0 || posQ.size() == 0) checkOutput("pos_unexpected", 1, 0);
                else begin
                    checkOutput("pos_lat", cyc, posCycQ.pop_front() + UPD_LAT);
                    checkOutput("pos_addr", pos_waddr, posQ.pop_front());
                end
            end
        end
    end

    task automatic busWrite(input int op, input int idx, input logic [63:0] data);
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1;
        addr = {7'(op), 9'(idx)}; writedata = data;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0; addr = '0; writedata = '0;
    endtask

    task automatic readStatus(output logic [63:0] d);
        @(negedge clk);
        chipselect = 1'b1; read = 1'b1; addr = '0;
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0;
        #1 d = readdata;
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1;
        addr = {v.op, v.idx}; writedata = v.data;
        #1;
        checkOutput("sw_wren", sw_wren, v.expWren);
        if (v.expWren != 0) begin
            checkOutput("sw_waddr", sw_waddr, v.idx);
            checkOutput("sw_wdata", sw_wdata, v.data);
        end
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0; addr = '0; writedata = '0;
    endtask

    task automatic startRun(input int n, input int steps);
        int se;
        pair_t pp;
        se = (steps == 0) ? 1 : steps;
        pairQ.delete(); velQ.delete(); posQ.delete(); lastCycQ.delete(); posCycQ.delete();
        pairCnt = 0; velCnt = 0; posCnt = 0; curN = n;
        for (int s = 0; s < se; s++) begin
            for (int i = 0; i < n; i++)
                for (int j = 0; j < n; j++)
                    if (i != j) begin
                        pp.i = 9'(i); pp.j = 9'(j); pp.last = (j == n - 1);
                        pairQ.push_back(pp);
                    end
            for (int i = 0; i < n; i++) velQ.push_back(9'(i));
            for (int k = 0; k < n; k++) posQ.push_back(9'(k));
        end
        monOn = 1'b1;
        busWrite(1, 0, 64'(n));
        busWrite(2, 0, 64'(steps));
        busWrite(0, 0, 64'h1);
    endtask

    task automatic finishRun(input int n, input int steps, input logic [63:0] expStatus);
        int w, se;
        se = (steps == 0) ? 1 : steps;
        w = 0;
        while (!done && w < 2000) begin
            @(negedge clk);
            w++;
        end
        checkOutput("done", done, 1);
        repeat (ACC_LAT + UPD_LAT + 2) @(negedge clk);
        checkOutput("pair_count", pairCnt, n * (n - 1) * se);
        checkOutput("vel_count", velCnt, n * se);
        checkOutput("pos_count", posCnt, n * se);
        checkOutput("queues_empty", pairQ.size() + velQ.size() + posQ.size(), 0);
        readStatus(st);
        checkOutput("status_done", st, expStatus);
        monOn = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout");
        $fatal(1, "[TB] bench did not terminate");
    end

    initial begin
        int w, velSeen, posSeen, pairSeen;
        vecs[0] = '{7'd3,   9'd5,   64'h3FF0_0000_0000_0000, 5'b00001};
        vecs[1] = '{7'd4,   9'd0,   64'h0000_0000_0000_0001, 5'b00010};
        vecs[2] = '{7'd5,   9'd511, 64'hAAAA_5555_AAAA_5555, 5'b00100};
        vecs[3] = '{7'd6,   9'd7,   64'h1234_5678_9ABC_DEF0, 5'b01000};
        vecs[4] = '{7'd7,   9'd2,   64'hFFFF_FFFF_FFFF_FFFF, 5'b10000};
        vecs[5] = '{7'd8,   9'd3,   64'hDEAD_BEEF_0000_0001, 5'b00000};
        vecs[6] = '{7'd127, 9'd9,   64'h0000_0000_0000_00FF, 5'b00000};

        rst = 1'b0; chipselect = 1'b0; write = 1'b0; read = 1'b0;
        addr = '0; writedata = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_readdata", readdata, 0);
        checkOutput("reset_sw", {sw_wren, sw_waddr, sw_wdata}, 0);
        checkOutput("reset_strobes", {pair_valid, pair_last, vel_wren, pos_rd_valid, pos_wren, busy, done}, 0);
        rst = 1'b1;
        readStatus(st);
        checkOutput("reset_status", st, 0);

        for (int v = 0; v < 7; v++) applyStimulus(vecs[v]);

        $display("[TB] pair loop n=3 steps=1");
        busWrite(0, 0, 64'h0);
        startRun(3, 1);
        finishRun(3, 1, 64'h0000_0000_4000_0015);

        $display("[TB] full step n=4 steps=2");
        busWrite(0, 0, 64'h0);
        startRun(4, 2);
        finishRun(4, 2, 64'h0000_0000_8000_0015);

        $display("[TB] steps=0 runs once");
        busWrite(0, 0, 64'h0);
        startRun(2, 0);
        finishRun(2, 0, 64'h0000_0000_4000_0015);

        $display("[TB] abort mid-ACCEL");
        busWrite(0, 0, 64'h0);
        busWrite(1, 0, 64'd4);
        busWrite(2, 0, 64'd5);
        busWrite(0, 0, 64'h1);
        w = 0;
        while (!(pair_last && pair_i == 9'd0) && w < 100) begin
            @(negedge clk);
            w++;
        end
        checkOutput("abort_reach_last", pair_last, 1);
        chipselect = 1'b1; write = 1'b1; addr = '0; writedata = 64'h2;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0; writedata = '0;
        #1 checkOutput("abort_busy", busy, 0);
        velSeen = 0; posSeen = 0; pairSeen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            velSeen += int'(vel_wren);
            posSeen += int'(pos_wren);
            pairSeen += int'(pair_valid);
        end
        checkOutput("abort_writebacks", {velSeen[15:0], posSeen[15:0], pairSeen[15:0]}, 0);
        readStatus(st);
        checkOutput("abort_status_state_done", {st[4:2], st[0]}, 0);

        $display("[TB] busy write error");
        busWrite(1, 0, 64'd4);
        busWrite(2, 0, 64'd3);
        busWrite(0, 0, 64'h1);
        repeat (3) @(negedge clk);
        chipselect = 1'b1; write = 1'b1; addr = {7'd3, 9'd5}; writedata = 64'h55;
        #1 checkOutput("busy_sw_wren", sw_wren, 0);
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0; addr = '0; writedata = '0;
        readStatus(st);
        checkOutput("busy_err_busy_bits", {st[5], st[1]}, 2'b11);
        busWrite(0, 0, 64'h0);
        readStatus(st);
        checkOutput("err_cleared", st[5], 0);
        busWrite(0, 0, 64'h2);

        $display("[TB] go with n_bodies<2");
        busWrite(1, 0, 64'd1);
        busWrite(0, 0, 64'h1);
        readStatus(st);
        checkOutput("small_n_status", st[29:0], 30'h35);
        busWrite(0, 0, 64'h1);
        readStatus(st);
        checkOutput("done_ignores_go", st[29:0], 30'h35);
        busWrite(0, 0, 64'h0);
        readStatus(st);
        checkOutput("done_to_idle", st[29:0], 30'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nbody_seq.md
Name: nbody_seq

Overview:
- Parametrised N-body step sequencer. It replaces the fixed 2-D controller with a DIMS-generic, latency-parametrised engine.
- It owns the software register interface, the go/done handshake and the i/j pair-issue loop for the acceleration phase.
- Latency-matched delay lines generate velocity and position write-backs to external per-channel RAMs. The arithmetic units (getAccl, leapfrog adders) sit outside this block and are fed by its issue outputs.

Parameters:
- BODIES, 512, maximum body count (power of two).
- DATA_WIDTH, 64, bus and RAM word width.
- ADDR_WIDTH, 16, bus address width.
- DIMS, 2, spatial dimensions (2 or 3).
- ACC_LAT, 60, cycles from pair issue to accumulated-accel-valid at the external accumulator.
- UPD_LAT, 20, cycles from position-read issue to updated position valid.
- BA, $clog2(BODIES), body-index field width (derived).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- chipselect  in  1  bus select
- write  in  1  bus write strobe
- read  in  1  bus read strobe
- addr  in  ADDR_WIDTH  [ADDR_WIDTH-1:BA]=opcode, [BA-1:0]=body index
- writedata  in  DATA_WIDTH  bus write data
- readdata  out  DATA_WIDTH  STATUS word, registered
- sw_waddr  out  BA  software RAM write address
- sw_wdata  out  DATA_WIDTH  software RAM write data
- sw_wren  out  2*DIMS+1  per-channel software write enable: [d]=pos d, [DIMS+d]=vel d, [2*DIMS]=mass
- pair_valid  out  1  i/j pair issued this cycle
- pair_i, pair_j  out  BA each  issued body indices
- pair_last  out  1  j is the final partner for i
- vel_wren  out  1  write accumulated velocity for vel_addr
- vel_addr  out  BA  velocity write-back address
- pos_rd_valid  out  1  position/velocity read issued
- pos_rd_addr  out  BA  position read address
- pos_wren  out  1  write updated position at pos_waddr
- pos_waddr  out  BA  position write-back address
- busy  out  1  state != IDLE && state != DONE
- done  out  1  run complete flag

Behaviour:
- Reset (rst==0 at posedge): state IDLE, all outputs 0, n_bodies=0, steps=0, step_cnt=0, delay lines cleared, err=0.
- Opcodes, acted on only when chipselect&&write:
  - 0 CTRL: wd[0]=go, wd[1]=abort.
  - 1 N_BODIES: wd[BA:0].
  - 2 STEPS: wd[31:0].
  - 3+c: write channel c, 0<=c<=2*DIMS; sw_wren[c] pulses the same cycle, sw_waddr=addr[BA-1:0], sw_wdata=writedata.
  - Other opcodes are ignored.
- Channel, N_BODIES or STEPS writes while busy: sw_wren stays 0 and sticky err is set. err clears on a CTRL write with go=0.
- Read, any opcode: readdata at the next cycle = {step_cnt[31:0], 24'b0, err, state[2:0], busy, done}.
- States:
  - IDLE: a CTRL write with go=1 and n_bodies>=2 moves to ACCEL with i=j=0 and step_cnt=0. If go=1 and n_bodies<2, set done, set err, go to DONE.
  - ACCEL: one pair per cycle. j increments; at j==n_bodies-1, j wraps to 0 and i increments. pair_valid=(i!=j). pair_last=(j==n_bodies-1); when i==j==n_bodies-1, pair_last still pulses with pair_valid=0. After the last pair, go to ACC_DRAIN.
  - ACC_DRAIN: wait for the delay line to empty, then go to POS with k=0.
  - POS: pos_rd_valid=1, pos_rd_addr=k, k++. After k==n_bodies-1, go to POS_DRAIN.
  - POS_DRAIN: wait for the delay line to empty, then step_cnt++. If step_cnt+1==steps, go to DONE (done=1); else go to ACCEL with i=j=0.
  - DONE: done held. A CTRL write with go=0 clears done and returns to IDLE. A CTRL write with go=1 is ignored.
- Accel delay line: ACC_LAT-deep shift of {pair_last, pair_i}. On output with last=1: vel_wren=1, vel_addr=i.
- Position delay line: UPD_LAT-deep shift of {pos_rd_valid, k}. On output: pos_wren=1, pos_waddr=k.
- steps==0 is treated as 1.
- abort=1 in any state: return to IDLE next cycle, clear both delay lines, done=0, no further write-backs.
- Simultaneous bus write and write-back in the same cycle is legal; the ports are independent.

Decomposition:
- nbody_pkg: state_t enum (IDLE, ACCEL, ACC_DRAIN, POS, POS_DRAIN, DONE), opcode localparams, STATUS field offsets.
- One sub-module, nbody_lat_pipe #(WIDTH, DEPTH): valid+payload shift register with synchronous clear. It is instanced twice.

Test Plan:
- Reset: hold rst=0 for 3 cycles -> all outputs 0, readdata STATUS=0.
- Load: write channel 0 at addr {3, idx 5}, data 0x3FF0_0000_0000_0000 -> sw_wren=1 (bit 0 only) same cycle, sw_waddr=5.
- Pair loop: n_bodies=3, steps=1, go -> exactly 6 pair_valid pulses, no i==j pair, 3 vel_wren pulses ACC_LAT cycles after each pair_last.
- Full step timing: n_bodies=4, steps=2, ACC_LAT=4, UPD_LAT=2 -> 4 pos_wren per step, done rises after step_cnt reaches 2, STATUS step_cnt=2.
- Abort: assert abort mid-ACCEL -> next cycle IDLE, busy=0, no subsequent vel_wren/pos_wren.
- Busy-write error: channel write during ACCEL -> sw_wren stays 0, STATUS err=1. CTRL go=0 clears err.
